// File: rtl/gf180mcu_fd_sc_mcu7t5v0__arb_pkg.sv
// Shared definitions for the library's small arbiter blocks.
//   gnt_t       : one-hot grant vector, bit 0 = requester 1
//   last_t      : last-grant pointer, encoded 1..3
//   next_rr()   : round-robin winner after pointer 'last'
//   gnt_to_last : converts a one-hot grant back to its pointer value
package gf180mcu_fd_sc_mcu7t5v0__arb_pkg;

  typedef logic [2:0] gnt_t;
  typedef logic [1:0] last_t;

  localparam gnt_t  G_NONE   = 3'b000;
  localparam gnt_t  G1       = 3'b001;
  localparam gnt_t  G2       = 3'b010;
  localparam gnt_t  G3       = 3'b100;
  // Pointing at requester 3 makes requester 1 the first candidate.
  localparam last_t LAST_RST = 2'd3;

  // Search order starts just after 'last' and wraps back to 'last' itself.
  function automatic gnt_t next_rr(input last_t last, input logic [2:0] req_vec);
    gnt_t win;
    win = G_NONE;
    case (last)
      2'd1: begin
        if      (req_vec[1]) win = G2;
        else if (req_vec[2]) win = G3;
        else if (req_vec[0]) win = G1;
      end
      2'd2: begin
        if      (req_vec[2]) win = G3;
        else if (req_vec[0]) win = G1;
        else if (req_vec[1]) win = G2;
      end
      // Encoding 0 never occurs; treat it like the reset pointer.
      default: begin
        if      (req_vec[0]) win = G1;
        else if (req_vec[1]) win = G2;
        else if (req_vec[2]) win = G3;
      end
    endcase
    return win;
  endfunction

  function automatic last_t gnt_to_last(input gnt_t g);
    last_t l;
    case (g)
      G1:      l = 2'd1;
      G2:      l = 2'd2;
      default: l = 2'd3;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__rrarb3_pick.sv
// Combinational round-robin picker.
//   req  : request vector, bit 0 = requester 1
//   last : last-grant pointer (1..3)
//   excl : requesters removed from the contest (preempted owner)
//   win  : one-hot winner, G_NONE when nothing eligible is pending
module gf180mcu_fd_sc_mcu7t5v0__rrarb3_pick
  import gf180mcu_fd_sc_mcu7t5v0__arb_pkg::*;
(
  input  logic [2:0] req,
  input  last_t      last,
  input  logic [2:0] excl,
  output gnt_t       win
);

  assign win = next_rr(last, req & ~excl);

endmodule

// File: rtl/gf180mcu_fd_sc_mcu7t5v0__rrarb3.sv
// Three-requester round-robin arbiter with registered one-hot grants.
// The owner keeps the resource while it requests; if others are waiting
// it is forced off after MAX_HOLD contested cycles (0 disables the limit).
// CNT_W must satisfy 2**CNT_W > MAX_HOLD.
//   CLK        : clock, rising edge
//   RST        : asynchronous active-high reset
//   REQ1..REQ3 : requests, synchronous to CLK
//   GNT1..GNT3 : registered one-hot grants
//   BUSY       : registered, high whenever a grant is active
//   VDD, VSS   : supply pins, carried for cell-library compatibility only
module gf180mcu_fd_sc_mcu7t5v0__rrarb3
  import gf180mcu_fd_sc_mcu7t5v0__arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 4,
  parameter int unsigned CNT_W    = 3
) (
  input  logic CLK,
  input  logic RST,
  input  logic REQ1,
  input  logic REQ2,
  input  logic REQ3,
  output logic GNT1,
  output logic GNT2,
  output logic GNT3,
  output logic BUSY,
  inout  wire  VDD,
  inout  wire  VSS
);

  // Last value HCNT reaches; the owner is preempted when it sits here.
  localparam logic [CNT_W-1:0] HOLD_TOP =
    (MAX_HOLD == 0) ? '0 : CNT_W'(MAX_HOLD - 1);

  logic [2:0]       req;
  gnt_t             gnt_q, gnt_d;
  last_t            last_q, last_d;
  logic [CNT_W-1:0] hcnt_q, hcnt_d;
  logic             busy_q;

  logic             own_req;
  logic             others;
  logic             at_limit;
  logic             preempt;
  logic [2:0]       excl;
  gnt_t             win;

  assign req      = {REQ3, REQ2, REQ1};
  assign own_req  = |(req & gnt_q);
  // When idle gnt_q is zero, so 'others' is simply "anyone requesting".
  assign others   = |(req & ~gnt_q);
  assign at_limit = (MAX_HOLD != 0) && (hcnt_q == HOLD_TOP);
  assign preempt  = (gnt_q != G_NONE) && own_req && others && at_limit;

  // Only a preempted owner is excluded; on release its request is already 0.
  assign excl = preempt ? gnt_q : G_NONE;

  gf180mcu_fd_sc_mcu7t5v0__rrarb3_pick u_pick (
    .req  (req),
    .last (last_q),
    .excl (excl),
    .win  (win)
  );

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    gnt_d  = gnt_q;
    last_d = last_q;
    hcnt_d = hcnt_q;

    if (gnt_q == G_NONE) begin
      if (|req) begin
        gnt_d  = win;
        last_d = gnt_to_last(win);
        hcnt_d = '0;
      end
    end else if (!own_req) begin
      // Release: hand over in the same edge, or go idle keeping LAST.
      hcnt_d = '0;
      if (others) begin
        gnt_d  = win;
        last_d = gnt_to_last(win);
      end else begin
        gnt_d = G_NONE;
      end
    end else if (preempt) begin
      gnt_d  = win;
      last_d = gnt_to_last(win);
      hcnt_d = '0;
    end else if (others && (MAX_HOLD != 0)) begin
      // Contested hold: count up, saturating at HOLD_TOP.
      if (!at_limit) hcnt_d = hcnt_q + CNT_W'(1);
    end else begin
      // Uncontested (or unlimited) hold never accumulates toward preemption.
      hcnt_d = '0;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of block evaluation order.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      gnt_q  <= G_NONE;
      last_q <= LAST_RST;
      hcnt_q <= '0;
      busy_q <= 1'b0;
    end else begin
      gnt_q  <= gnt_d;
      last_q <= last_d;
      hcnt_q <= hcnt_d;
      busy_q <= (gnt_d != G_NONE);
    end
  end

  assign GNT1 = gnt_q[0];
  assign GNT2 = gnt_q[1];
  assign GNT3 = gnt_q[2];
  assign BUSY = busy_q;

  // Supply pins have no logical function; fold them into a sink net.
  logic unused_supply;
  assign unused_supply = VDD ^ VSS;

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu7t5v0__rrarb3.sv
// Self-checking bench: two arbiters (MAX_HOLD=4 and MAX_HOLD=0) share the
// same requests; a behavioural model for each is compared every cycle, and
// directed scenarios add literal expectations.
module tb_gf180mcu_fd_sc_mcu7t5v0__rrarb3;

  logic       clk;
  logic       rst;
  logic [3:1] req;
  wire        vdd = 1'b1;
  wire        vss = 1'b0;

  wire gh1, gh2, gh3, bh;
  wire gn1, gn2, gn3, bn;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  gf180mcu_fd_sc_mcu7t5v0__rrarb3 #(.MAX_HOLD(4), .CNT_W(3)) dut_h (
    .CLK(clk), .RST(rst), .REQ1(req[1]), .REQ2(req[2]), .REQ3(req[3]),
    .GNT1(gh1), .GNT2(gh2), .GNT3(gh3), .BUSY(bh), .VDD(vdd), .VSS(vss)
  );

  gf180mcu_fd_sc_mcu7t5v0__rrarb3 #(.MAX_HOLD(0), .CNT_W(3)) dut_n (
    .CLK(clk), .RST(rst), .REQ1(req[1]), .REQ2(req[2]), .REQ3(req[3]),
    .GNT1(gn1), .GNT2(gn2), .GNT3(gn3), .BUSY(bn), .VDD(vdd), .VSS(vss)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int actual, input int expected);
    n_tests++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Owner is a requester number (0 = nobody); the winner is found by walking
  // requester numbers upward from the last grant with modular arithmetic.
  function automatic int rr_pick(input int last, input bit [3:1] r, input int excl);
    for (int i = 1; i <= 3; i++) begin
      int c;
      c = ((last + i - 1) % 3) + 1;
      if (c != excl && r[c]) return c;
    end
    return 0;
  endfunction

  // cnt = contested cycles the current owner has already been kept.
  task automatic model_step(input int own, input int last, input int cnt,
                            input int max_hold, input bit [3:1] r,
                            output int n_own, output int n_last, output int n_cnt);
    bit waiting;
    int w;
    waiting = 1'b0;
    for (int i = 1; i <= 3; i++) if (i != own && r[i]) waiting = 1'b1;
    n_own = own; n_last = last; n_cnt = cnt;
    if (own == 0) begin
      w = rr_pick(last, r, 0);
      if (w != 0) begin n_own = w; n_last = w; n_cnt = 0; end
    end else if (!r[own]) begin
      w = rr_pick(last, r, 0);
      n_own = w; n_cnt = 0;
      if (w != 0) n_last = w;
    end else if (max_hold != 0 && waiting && cnt + 1 >= max_hold) begin
      w = rr_pick(last, r, own);
      n_own = w; n_last = w; n_cnt = 0;
    end else begin
      n_cnt = waiting ? cnt + 1 : 0;
    end
  endtask

  int mh_own = 0, mh_last = 3, mh_cnt = 0;
  int mn_own = 0, mn_last = 3, mn_cnt = 0;

  always @(posedge clk or posedge rst) begin : model
    int o, l, c;
    if (rst) begin
      mh_own <= 0; mh_last <= 3; mh_cnt <= 0;
      mn_own <= 0; mn_last <= 3; mn_cnt <= 0;
    end else begin
      model_step(mh_own, mh_last, mh_cnt, 4, req, o, l, c);
      mh_own <= o; mh_last <= l; mh_cnt <= c;
      model_step(mn_own, mn_last, mn_cnt, 0, req, o, l, c);
      mn_own <= o; mn_last <= l; mn_cnt <= c;
    end
  end

  function automatic int onehot(input int own);
    return (own == 0) ? 0 : (1 << (own - 1));
  endfunction

  // Every-cycle compare, sampled on the falling edge.
  always @(negedge clk) begin
    if (chk_en) begin
      check("h_gnt_model", int'({gh3, gh2, gh1}), onehot(mh_own));
      check("h_busy_model", int'(bh), int'(mh_own != 0));
      check("h_onehot", int'($countones({gh3, gh2, gh1}) <= 1), 1);
      check("h_busy_or", int'(bh), int'(gh1 | gh2 | gh3));
      check("n_gnt_model", int'({gn3, gn2, gn1}), onehot(mn_own));
      check("n_busy_model", int'(bn), int'(mn_own != 0));
      check("n_onehot", int'($countones({gn3, gn2, gn1}) <= 1), 1);
      check("n_busy_or", int'(bn), int'(gn1 | gn2 | gn3));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 3'b000;
    repeat (2) tick();
    rst = 1'b0;
  endtask

  function automatic int gh();
    return int'({gh3, gh2, gh1});
  endfunction

  function automatic int gn();
    return int'({gn3, gn2, gn1});
  endfunction

  initial begin
    rst = 1'b1;
    req = 3'b000;
    tick();
    do_reset();
    chk_en = 1'b1;

    // Reset state.
    check("rst_gnt_h", gh(), 0);
    check("rst_busy_h", int'(bh), 0);
    check("rst_gnt_n", gn(), 0);

    // All three from reset: requester 1 first, one edge later.
    req = 3'b111;
    tick();
    check("all3_gnt_h", gh(), 1);
    check("all3_busy_h", int'(bh), 1);
    check("all3_gnt_n", gn(), 1);

    // REQ1+REQ2: hold limit alternates every 4 cycles; no limit keeps GNT1.
    do_reset();
    req = 3'b011;
    for (int n = 0; n < 24; n++) begin
      tick();
      check("rot_h", gh(), ((n / 4) % 2 == 0) ? 1 : 2);
      check("rot_n", gn(), 1);
    end

    // REQ3 alone for 20 cycles: no competition, no preemption.
    do_reset();
    req = 3'b100;
    for (int n = 0; n < 20; n++) begin
      tick();
      check("solo3_h", gh(), 4);
    end
    req = 3'b000;
    tick();
    check("solo3_drop_gnt", gh(), 0);
    check("solo3_drop_busy", int'(bh), 0);

    // Release hands over with no idle bubble.
    do_reset();
    req = 3'b001;
    tick();
    check("hand_own1", gh(), 1);
    req = 3'b011;
    tick();
    check("hand_keep1", gh(), 1);
    req = 3'b010;
    tick();
    check("hand_gnt2", gh(), 2);
    check("hand_busy", int'(bh), 1);

    // Asynchronous reset mid-cycle while GNT2 is held.
    do_reset();
    req = 3'b010;
    tick();
    check("arst_pre", gh(), 2);
    #2 rst = 1'b1;
    #1;
    check("arst_gnt_h", gh(), 0);
    check("arst_busy_h", int'(bh), 0);
    check("arst_gnt_n", gn(), 0);
    tick();
    rst = 1'b0;
    req = 3'b110;
    tick();
    check("arst_resume", gh(), 2);

    // No hold limit: everyone requesting for 50 cycles keeps GNT1.
    do_reset();
    req = 3'b111;
    for (int n = 0; n < 50; n++) begin
      tick();
      check("nolimit_n", gn(), 1);
    end

    // Random traffic, compared against the model every cycle.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      tick();
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        for (int i = 1; i <= 3; i++)
          if ($urandom_range(0, 3) == 0) req[i] = ~req[i];
      end
    end

    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
